// File: rtl/bus_arbiter_pkg.sv
// Shared types for the DBUS arbiter: arbitration states, bus owner codes
// and the state-to-owner mapping used to drive the OWNER output.
// Latency: n/a (types only). Backpressure: n/a.
package bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CPU    = 3'd1,
        DMA    = 3'd2,
        EXT_HO = 3'd3,   // one-cycle bus turnaround before the external master
        EXT    = 3'd4
    } ArbState_t;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_DMA  = 2'd2,
        OWNER_EXT  = 2'd3
    } ArbOwner_t;

    // The turnaround state reports no owner: nobody drives the bus there.
    function automatic ArbOwner_t owner_of(input ArbState_t st);
        ArbOwner_t own;
        own = OWNER_NONE;
        case (st)
            CPU:     own = OWNER_CPU;
            DMA:     own = OWNER_DMA;
            EXT:     own = OWNER_EXT;
            default: own = OWNER_NONE;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Purpose: grants the shared DBUS to CPU, DMAC or an external master with lock and DMA hold limits.
// Latency: grant registered, visible on the first CE_R edge after the request is sampled.
// Backpressure: requesters not granted are stalled; CPU_STALL = CPU_REQ & ~CPU_GNT.
//
// Ports: CLK/RST (sync, active-high, independent of CE_R), CE_R qualifies all
// state updates; CPU_REQ/CPU_LOCK, DMA_REQ/DMA_LOCK/DMA_BURST, EXT_BREQ and
// BSC_ACK (access completion) in; one-hot CPU_GNT/DMA_GNT/EXT_BACK, CPU_STALL
// and OWNER (0 none, 1 CPU, 2 DMA, 3 EXT) out.
// Optional macro BUS_ARB_EXT_MASTER_EN enables the external master path; when
// undefined EXT_BREQ is ignored, EXT_BACK is 0 and OWNER never reads 3.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE_R,
    input  logic       CPU_REQ,
    input  logic       CPU_LOCK,
    input  logic       DMA_REQ,
    input  logic       DMA_LOCK,
    input  logic       DMA_BURST,
    input  logic       EXT_BREQ,
    input  logic       BSC_ACK,
    output logic       CPU_GNT,
    output logic       DMA_GNT,
    output logic       EXT_BACK,
    output logic       CPU_STALL,
    output logic [1:0] OWNER
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    ArbState_t        state, state_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
    logic             yield, yield_nxt;

    logic ext_req;
    logic arb_point;
    logic dma_ack;
    logic yield_set;
    logic yield_eff;

`ifdef BUS_ARB_EXT_MASTER_EN
    assign ext_req = EXT_BREQ;
`else
    logic ext_breq_unused;
    assign ext_breq_unused = EXT_BREQ;
    assign ext_req         = 1'b0;
`endif

    // An owner only gives up the bus on an unlocked completion; a lock that
    // drops in the same cycle as BSC_ACK counts as unlocked.
    always_comb begin
        arb_point = 1'b0;
        case (state)
            IDLE:    arb_point = 1'b1;
            CPU:     arb_point = BSC_ACK && !CPU_LOCK;
            DMA:     arb_point = BSC_ACK && !DMA_LOCK;
            default: arb_point = 1'b0;
        endcase
    end

    // The yield earned by the completing DMA access must already count in the
    // arbitration of that same cycle, otherwise cycle-steal would re-grant DMA.
    assign dma_ack   = (state == DMA) && BSC_ACK;
    assign yield_set = dma_ack && (!DMA_BURST || (burst_cnt >= CNT_LAST));
    assign yield_eff = yield || yield_set;

    always_comb begin
        state_nxt = state;
        if (arb_point) begin
            if (ext_req)
                state_nxt = EXT_HO;
            else if (yield_eff && CPU_REQ)
                state_nxt = CPU;
            else if (DMA_REQ)
                state_nxt = DMA;
            else if (CPU_REQ)
                state_nxt = CPU;
            else
                state_nxt = IDLE;
        end
`ifdef BUS_ARB_EXT_MASTER_EN
        else if (state == EXT_HO)
            state_nxt = EXT;
        else if ((state == EXT) && !ext_req)
            state_nxt = IDLE;  // turnaround cycle before normal arbitration
`endif
    end

    always_comb begin
        burst_cnt_nxt = burst_cnt;
        if (state_nxt != DMA)
            burst_cnt_nxt = '0;
        else if (dma_ack)
            burst_cnt_nxt = (burst_cnt >= CNT_MAX) ? CNT_MAX : burst_cnt + 1'b1;
    end

    // Clearing wins over setting: a CPU grant or an idle CPU consumes the debt.
    always_comb begin
        yield_nxt = yield;
        if (yield_set)
            yield_nxt = 1'b1;
        if ((state_nxt == CPU) || (arb_point && !CPU_REQ))
            yield_nxt = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            burst_cnt <= '0;
            yield     <= 1'b0;
        end else if (CE_R) begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
            yield     <= yield_nxt;
        end
    end

    assign CPU_GNT   = (state == CPU);
    assign DMA_GNT   = (state == DMA);
`ifdef BUS_ARB_EXT_MASTER_EN
    assign EXT_BACK  = (state == EXT);
`else
    assign EXT_BACK  = 1'b0;
`endif
    assign CPU_STALL = CPU_REQ && !CPU_GNT;
    assign OWNER     = owner_of(state);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: vector table, directed multi-cycle sequences and
// randomized traffic checked against a behavioural ownership model.
module tb_bus_arbiter;

    localparam int MAXB = 4;
`ifdef BUS_ARB_EXT_MASTER_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    localparam int W_NONE = 0;
    localparam int W_CPU  = 1;
    localparam int W_DMA  = 2;
    localparam int W_EXT  = 3;

    logic       clk;
    logic       rst, ce, cpu_req, cpu_lock, dma_req, dma_lock, dma_burst, breq, ack;
    logic       cpu_gnt, dma_gnt, ext_back, cpu_stall;
    logic [1:0] owner;

    int n_vec;
    int n_fail;

    // Behavioural model: who holds the bus, a pending external handoff,
    // DMA accesses completed in the current tenure, and the CPU's owed slot.
    int m_who;
    bit m_ext_wait;
    int m_run;
    bit m_owed;

    bus_arbiter #(.MAX_BURST(MAXB), .CNT_W(8)) dut (
        .CLK(clk), .RST(rst), .CE_R(ce),
        .CPU_REQ(cpu_req), .CPU_LOCK(cpu_lock),
        .DMA_REQ(dma_req), .DMA_LOCK(dma_lock), .DMA_BURST(dma_burst),
        .EXT_BREQ(breq), .BSC_ACK(ack),
        .CPU_GNT(cpu_gnt), .DMA_GNT(dma_gnt), .EXT_BACK(ext_back),
        .CPU_STALL(cpu_stall), .OWNER(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic decide();
        if (EXT_EN && breq) begin
            m_ext_wait = 1'b1;
            m_who      = W_NONE;
        end else if (m_owed && cpu_req)
            m_who = W_CPU;
        else if (dma_req)
            m_who = W_DMA;
        else if (cpu_req)
            m_who = W_CPU;
        else
            m_who = W_NONE;
        if (m_who != W_DMA) m_run = 0;
        if (m_who == W_CPU || !cpu_req) m_owed = 1'b0;
    endtask

    task automatic model_step();
        if (rst) begin
            m_who = W_NONE; m_ext_wait = 1'b0; m_run = 0; m_owed = 1'b0;
        end else if (ce) begin
            if (m_ext_wait) begin
                m_ext_wait = 1'b0;
                m_who      = W_EXT;
            end else begin
                case (m_who)
                    W_NONE: decide();
                    W_EXT:  if (!breq) m_who = W_NONE;
                    W_CPU:  if (ack && !cpu_lock) decide();
                    default: if (ack) begin
                        m_run = (m_run < MAXB) ? m_run + 1 : MAXB;
                        if (!dma_burst || m_run == MAXB) m_owed = 1'b1;
                        if (!dma_lock) decide();
                    end
                endcase
            end
        end
    endtask

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cycle(input string nm);
        logic [1:0] own;
        model_step();
        @(posedge clk);
        #1;
        own = 2'(m_who);
        check(nm, {3'b000, cpu_gnt, dma_gnt, ext_back, owner},
              {3'b000, m_who == W_CPU, m_who == W_DMA, m_who == W_EXT, own});
        check({nm, "_stall"}, {7'd0, cpu_stall}, {7'd0, cpu_req && (m_who != W_CPU)});
    endtask

    task automatic set_in(input logic [7:0] v, input logic b);
        {rst, ce, cpu_req, cpu_lock, dma_req, dma_lock, dma_burst, ack} = v;
        breq = b;
    endtask

    task automatic do_reset();
        set_in(8'b1000_0000, 1'b0);
        cycle("reset");
        rst = 1'b0;
        ce  = 1'b1;
    endtask

    typedef struct {
        logic [7:0] in;   // rst, ce, cpu_req, cpu_lock, dma_req, dma_lock, burst, ack
        logic [1:0] own;
    } vec_t;

    vec_t       tbl[16];
    logic [1:0] burst_exp[9];
    logic [1:0] ext_exp[8];
    logic [1:0] e;

    initial begin
        n_vec = 0; n_fail = 0;
        m_who = 0; m_ext_wait = 0; m_run = 0; m_owed = 0;
        set_in(8'b1000_0000, 1'b0);

        tbl[0]  = '{8'b1000_0000, 2'd0};  // reset state
        tbl[1]  = '{8'b0110_0000, 2'd1};  // CPU alone, 1 cycle latency
        tbl[2]  = '{8'b0110_0000, 2'd1};
        tbl[3]  = '{8'b0111_1001, 2'd1};  // locked ack holds CPU
        tbl[4]  = '{8'b0110_1001, 2'd2};  // DMA outranks CPU
        tbl[5]  = '{8'b0110_1000, 2'd2};
        tbl[6]  = '{8'b0110_1001, 2'd1};  // cycle-steal yield
        tbl[7]  = '{8'b0110_1001, 2'd2};
        tbl[8]  = '{8'b0010_1001, 2'd2};  // CE_R=0 freezes
        tbl[9]  = '{8'b0100_0001, 2'd0};  // nobody requesting
        tbl[10] = '{8'b0100_1000, 2'd2};
        tbl[11] = '{8'b1000_1000, 2'd0};  // reset with CE_R=0
        tbl[12] = '{8'b0110_1000, 2'd2};  // normal priority after reset
        tbl[13] = '{8'b0110_1101, 2'd2};  // DMA lock on ack
        tbl[14] = '{8'b0110_1001, 2'd1};  // lock drop with ack = unlocked
        tbl[15] = '{8'b0100_1001, 2'd2};
        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].in, 1'b0);
            cycle("tbl_model");
            e = tbl[i].own;
            check($sformatf("tbl%0d", i), {3'b000, cpu_gnt, dma_gnt, ext_back, owner},
                  {3'b000, e == 2'd1, e == 2'd2, 1'b0, e});
        end

        // CPU alone, completion every second cycle: held without a bubble.
        do_reset();
        cpu_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ack = i[0];
            cycle("cpu_alone_model");
            check("cpu_alone", {4'd0, cpu_gnt, owner, cpu_stall}, 8'b0000_1010);
        end

        // Burst mode with MAX_BURST=4: 4 DMA, 1 CPU, 4 DMA, 1 CPU.
        burst_exp = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
        do_reset();
        cpu_req = 1'b1; dma_req = 1'b1; dma_burst = 1'b1;
        cycle("burst_grant");
        check("burst_first", {6'd0, owner}, 8'd2);
        ack = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cycle("burst_model");
            check($sformatf("burst_ack%0d", i + 1), {6'd0, owner}, {6'd0, burst_exp[i]});
        end

        // CPU lock keeps the pending DMAC out until an unlocked completion.
        do_reset();
        cpu_req = 1'b1;
        cycle("lock_grant");
        cpu_lock = 1'b1; dma_req = 1'b1; ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle("cpu_lock_model");
            check("cpu_lock_hold", {6'd0, dma_gnt, cpu_gnt}, 8'b01);
        end
        cpu_lock = 1'b0;
        cycle("cpu_unlock_model");
        check("cpu_unlock", {6'd0, owner}, 8'd2);

`ifdef BUS_ARB_EXT_MASTER_EN
        // Locked DMA ignores EXT; then turnaround, EXT tenure, idle, CPU.
        ext_exp = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd0, 2'd1};
        do_reset();
        cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b1;
        cycle("ext_grant");
        check("ext_dma_first", {6'd0, owner}, 8'd2);
        for (int i = 0; i < 8; i++) begin
            ack      = (i < 4);
            breq     = (i < 6);
            dma_lock = (i < 3);
            cycle("ext_model");
            check($sformatf("ext_step%0d", i), {5'd0, ext_back, owner},
                  {5'd0, ext_exp[i] == 2'd3, ext_exp[i]});
        end
`else
        // Without external master support EXT_BREQ has no effect.
        do_reset();
        cpu_req = 1'b1; breq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ack = i[0];
            cycle("noext_model");
            check("noext", {5'd0, ext_back, owner}, 8'b0000_0001);
        end
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            ce        = ($urandom_range(0, 3) != 0);
            cpu_req   = ($urandom_range(0, 2) != 0);
            dma_req   = ($urandom_range(0, 2) != 0);
            cpu_lock  = ($urandom_range(0, 3) == 0);
            dma_lock  = ($urandom_range(0, 3) == 0);
            ack       = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 15) == 0) dma_burst = ~dma_burst;
            if ($urandom_range(0, 9) == 0) breq = ~breq;
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Owns the shared data bus (DBUS) and grants it to one of three masters: the CPU, the DMAC, or an external bus master.
- Sits between the CPU/DMAC request side and the bus state controller (BSC).
- Applies priority, enforces lock, and limits DMA hold time (cycle-steal and burst modes).
- Produces one-hot grants and stalls the requesters that are not granted.

Parameters:
- MAX_BURST, 16: maximum consecutive DMA accesses in burst mode before the DMAC must yield one slot to a pending CPU request. Range 1..255.
- CNT_W, 8: width of the burst counter. Must satisfy 2^CNT_W > MAX_BURST.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- CE_R  in  1  rising-phase clock enable; all state updates are qualified by it
- CPU_REQ  in  1  CPU requests a bus access
- CPU_LOCK  in  1  CPU read-modify-write lock; hold the grant while it is set
- DMA_REQ  in  1  DMAC requests a bus access
- DMA_LOCK  in  1  DMAC longword/16-byte group lock; hold the grant while it is set
- DMA_BURST  in  1  1 = burst mode, 0 = cycle-steal mode
- EXT_BREQ  in  1  external master bus request, active-high
- BSC_ACK  in  1  one-cycle pulse from the BSC marking completion of the current access
- CPU_GNT  out  1  CPU owns the bus
- DMA_GNT  out  1  DMAC owns the bus
- EXT_BACK  out  1  bus released to the external master
- CPU_STALL  out  1  CPU_REQ & ~CPU_GNT (combinational)
- OWNER  out  2  0 = none, 1 = CPU, 2 = DMA, 3 = EXT

Behaviour:
- Reset: while RST=1 at a CLK edge, state <= IDLE, all grants 0, OWNER 0, burst counter 0, yield flag 0. This is independent of CE_R. A reset during an active access drops the grant at that edge; the access is abandoned.
- Grants are registered and updated only when CE_R=1. CPU_GNT, DMA_GNT and EXT_BACK are mutually exclusive; they are never asserted together.
- States: IDLE, CPU, DMA, EXT_HO, EXT.
- Arbitration point: state IDLE, or any owner state on a CE_R cycle with BSC_ACK=1 and the owner's lock=0.
- Priority at an arbitration point: EXT_BREQ, then DMA_REQ, then CPU_REQ.
  - Exception: if the yield flag is set and CPU_REQ=1, the CPU wins over the DMAC.
- IDLE -> winner's state. The grant is visible on the first CE_R edge after the request is sampled (latency 1 CE_R cycle).
- CPU / DMA states:
  - On BSC_ACK with no lock: re-arbitrate. The same owner may be re-granted with no bubble.
  - If no request is pending, go to IDLE.
  - While the owner's lock=1, EXT_BREQ and the other master are ignored.
- Burst counter:
  - Increments on each DMA BSC_ACK; saturates at MAX_BURST.
  - Cleared when ownership leaves DMA.
  - Cycle-steal (DMA_BURST=0): the yield flag is set after every DMA BSC_ACK.
  - Burst (DMA_BURST=1): the yield flag is set when the count reaches MAX_BURST.
  - The yield flag is cleared when the CPU is granted, or at an arbitration point with CPU_REQ=0.
- EXT handoff:
  - Winning EXT moves the arbiter to EXT_HO for exactly one CE_R cycle with all grants 0 (bus turnaround), then to EXT with EXT_BACK=1.
  - EXT holds until EXT_BREQ=0; then one turnaround cycle in IDLE with no grant, then normal arbitration.
- Simultaneous events:
  - BSC_ACK together with a lock deassert on the same cycle counts as an unlocked completion.
  - A lock asserted in the same cycle as the grant is honoured from that cycle.
- OWNER mirrors the current state; EXT_HO reports 0.

Optional Feature:
- Macro: BUS_ARB_EXT_MASTER_EN.
- Defined: external master support as described above.
- Undefined:
  - EXT_BREQ is ignored.
  - EXT_BACK is tied to 0.
  - States EXT_HO and EXT are not generated; the arbiter is two-master only.
  - OWNER never reads 3.

Decomposition:
- Shared package (alongside the existing SH7604 package): ArbState_t enum (IDLE, CPU, DMA, EXT_HO, EXT), ArbOwner_t 2-bit enum, OWNER_* constants.
- Single module; the burst/yield counter stays inline. No sub-module.

Test Plan:
- CPU_REQ=1 alone, BSC_ACK every 2 CE_R cycles -> CPU_GNT=1 one CE_R cycle after request, OWNER=1, held continuously, CPU_STALL=0.
- CPU_REQ=1 and DMA_REQ=1, DMA_BURST=0 -> grant sequence per BSC_ACK is DMA, CPU, DMA, CPU.
- DMA_BURST=1, MAX_BURST=4, both requesting -> 4 DMA accesses, then 1 CPU, then 4 DMA; counter resets to 0 on handoff.
- DMA_LOCK=1 across 4 ACKs with EXT_BREQ=1 raised at ACK 1 -> DMA_GNT held for all 4; then one cycle with all grants 0 (EXT_HO); then EXT_BACK=1; EXT_BREQ=0 -> one idle cycle, then CPU granted.
- CPU_LOCK=1 with DMA_REQ pending -> DMA_STALL-equivalent: DMA_GNT=0 until lock drops at an ACK.
- RST=1 mid-DMA with DMA_GNT=1 -> all outputs 0 at the next CLK edge even with CE_R=0; after release, the first grant follows normal priority.
